parity_frame_receiver: RTL and testbench



---
 rtl/parity_frame_receiver.sv | 183 ++++++++++++++++++
 tb/tb_parity_frame_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_receiver.sv
// Even-parity serial frame receiver: start, DATA_WIDTH data bits LSB first, parity, stop.
// Define PARITY_RX_ERR_COUNT_EN to add the saturating err_count output.
module parity_frame_receiver #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
`ifdef PARITY_RX_ERR_COUNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    pbit_q, pbit_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    parity_error_q, parity_error_d;
  logic                    framing_error_q, framing_error_d;
  logic                    busy_q, busy_d;
  logic                    s;
  logic                    frame_perr;

`ifdef PARITY_RX_ERR_COUNT_EN
  logic [7:0]              err_count_q, err_count_d;
`endif

  assign s = sync2_q;

  always_comb begin
    state_d         = state_q;
    sync1_d         = rx_serial;
    sync2_d         = sync1_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    pbit_d          = pbit_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    frame_perr      = (^shift_q) ^ pbit_q;

    unique case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          shift_d[idx_q] = s;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          pbit_d  = s;
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          rx_data_d       = shift_q;
          parity_error_d  = frame_perr;
          framing_error_d = ~s;
          rx_valid_d      = 1'b1;
          cnt_d           = '0;
          // Returning to IDLE at mid-stop lets a back-to-back start bit be caught.
          state_d         = s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

`ifdef PARITY_RX_ERR_COUNT_EN
  always_comb begin
    err_count_d = err_count_q;
    if (rx_valid_d && parity_error_d && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      pbit_q          <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      pbit_q          <= pbit_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      busy_q          <= busy_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver (default parameters, optional err_count).
module tb_parity_frame_receiver;

  localparam int DW  = 4;
  localparam int CPB = 4;

  logic          clk;
  logic          rst;
  logic          rx_serial;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;
`ifdef PARITY_RX_ERR_COUNT_EN
  logic [7:0]    err_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  logic busy_seen = 1'b0;
  logic [DW-1:0] cap_data [0:31];
  logic          cap_perr [0:31];
  logic          cap_ferr [0:31];
  int            cap_cyc  [0:31];

  parity_frame_receiver #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
`ifdef PARITY_RX_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (rx_valid === 1'b1 && valid_cnt < 32) begin
      cap_data[valid_cnt] = rx_data;
      cap_perr[valid_cnt] = parity_error;
      cap_ferr[valid_cnt] = framing_error;
      cap_cyc[valid_cnt]  = cyc;
      valid_cnt = valid_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  task automatic idle_cycles(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;
  int t0;

  initial begin
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_parity_error", 32'(parity_error), 32'h0);
    check("reset_framing_error", 32'(framing_error), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
`ifdef PARITY_RX_ERR_COUNT_EN
    check("reset_err_count", 32'(err_count), 32'h0);
`endif
    rst = 1'b0;
    idle_cycles(4);

    // Frame 1010, parity 0: 2 sync flops + IDLE detect edge + 26 cycles of frame timing.
    base = valid_cnt;
    t0 = cyc;
    send_frame(4'b1010, 1'b0, 1'b1);
    idle_cycles(6);
    check("f1_count", 32'(valid_cnt - base), 32'd1);
    check("f1_data", 32'(cap_data[base]), 32'hA);
    check("f1_perr", 32'(cap_perr[base]), 32'h0);
    check("f1_ferr", 32'(cap_ferr[base]), 32'h0);
    check("f1_latency", 32'(cap_cyc[base] - t0), 32'd29);

    // Back-to-back frames 1110/p1 and 0001/p1.
    base = valid_cnt;
    send_frame(4'b1110, 1'b1, 1'b1);
    send_frame(4'b0001, 1'b1, 1'b1);
    idle_cycles(6);
    check("b2b_count", 32'(valid_cnt - base), 32'd2);
    check("b2b_data0", 32'(cap_data[base]), 32'hE);
    check("b2b_perr0", 32'(cap_perr[base]), 32'h0);
    check("b2b_data1", 32'(cap_data[base+1]), 32'h1);
    check("b2b_perr1", 32'(cap_perr[base+1]), 32'h0);

    // Parity error: 1010 with parity 1.
`ifdef PARITY_RX_ERR_COUNT_EN
    check("errcnt_before", 32'(err_count), 32'h0);
`endif
    base = valid_cnt;
    send_frame(4'b1010, 1'b1, 1'b1);
    idle_cycles(6);
    check("perr_count", 32'(valid_cnt - base), 32'd1);
    check("perr_data", 32'(cap_data[base]), 32'hA);
    check("perr_flag", 32'(cap_perr[base]), 32'h1);
    check("perr_hold", 32'(parity_error), 32'h1);
`ifdef PARITY_RX_ERR_COUNT_EN
    check("errcnt_after", 32'(err_count), 32'h1);
`endif

    // One-cycle glitch: start detected, rejected at mid start bit.
    base = valid_cnt;
    busy_seen = 1'b0;
    rx_serial = 1'b0;
    @(posedge clk);
    #1;
    rx_serial = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_seen", 32'(busy_seen), 32'h1);
    check("glitch_busy_clear", 32'(busy), 32'h0);
    idle_cycles(30);
    check("glitch_no_valid", 32'(valid_cnt - base), 32'd0);

    // Stop bit 0 with line held low, then a clean 0110 frame.
    base = valid_cnt;
    send_frame(4'b0011, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("ferr_count", 32'(valid_cnt - base), 32'd1);
    check("ferr_data", 32'(cap_data[base]), 32'h3);
    check("ferr_flag", 32'(cap_ferr[base]), 32'h1);
    check("ferr_busy_low_line", 32'(busy), 32'h1);
    idle_cycles(4);
    check("ferr_idle_after_high", 32'(busy), 32'h0);
    send_frame(4'b0110, 1'b0, 1'b1);
    idle_cycles(6);
    check("ferr_total_count", 32'(valid_cnt - base), 32'd2);
    check("ferr_next_data", 32'(cap_data[base+1]), 32'h6);
    check("ferr_next_flag", 32'(cap_ferr[base+1]), 32'h0);
    check("ferr_next_perr", 32'(cap_perr[base+1]), 32'h0);

    // Reset during DATA, then a full 1010 frame.
    base = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rx_serial = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_rx_data", 32'(rx_data), 32'h0);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_perr", 32'(parity_error), 32'h0);
    check("midrst_ferr", 32'(framing_error), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
`ifdef PARITY_RX_ERR_COUNT_EN
    check("midrst_err_count", 32'(err_count), 32'h0);
`endif
    idle_cycles(30);
    check("midrst_no_valid", 32'(valid_cnt - base), 32'd0);
    send_frame(4'b1010, 1'b0, 1'b1);
    idle_cycles(6);
    check("post_rst_count", 32'(valid_cnt - base), 32'd1);
    check("post_rst_data", 32'(cap_data[base]), 32'hA);
    check("post_rst_perr", 32'(cap_perr[base]), 32'h0);
    check("post_rst_ferr", 32'(cap_ferr[base]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
